// File: rtl/poly_halve_seq_if.sv
// Control and coefficient-RAM bundle between poly-arith control, the halving sequencer and a 1R1W RAM.
// slave: the sequencer side (takes start/shift/read data, drives status and both RAM ports).
// master: the control + RAM side.
interface poly_halve_seq_if #(
  parameter int ADDR_W  = 8,
  parameter int SHIFT_W = 3
);
  logic               start_i;
  logic [SHIFT_W-1:0] shift_i;
  logic               busy_o;
  logic               done_o;
  logic               rd_en_o;
  logic [ADDR_W-1:0]  rd_addr_o;
  logic [11:0]        rd_data_i;
  logic               wr_en_o;
  logic [ADDR_W-1:0]  wr_addr_o;
  logic [11:0]        wr_data_o;

  modport slave (
    input  start_i, shift_i, rd_data_i,
    output busy_o, done_o, rd_en_o, rd_addr_o, wr_en_o, wr_addr_o, wr_data_o
  );

  modport master (
    output start_i, shift_i, rd_data_i,
    input  busy_o, done_o, rd_en_o, rd_addr_o, wr_en_o, wr_addr_o, wr_data_o
  );
endinterface

// File: rtl/poly_halve_seq.sv
// Scales a polynomial in a 1R1W coefficient RAM by 2^-k mod 3329 in place, one halving pass per k.
// Latency: k*(N_COEFFS+2) cycles from the start edge to done_o (1 cycle when k=0).
// No backpressure: the RAM is assumed to accept one read and one write per cycle; start_i is ignored unless IDLE.
// Ports: clk/rst (sync, active-high); bus.start_i/shift_i request, bus.busy_o/done_o status,
//        bus.rd_* read port (data one cycle after rd_en_o), bus.wr_* write port (data = half of rd_data_i).
module poly_halve_seq #(
  parameter int N_COEFFS = 256,
  parameter int ADDR_W   = $clog2(N_COEFFS),
  parameter int SHIFT_W  = 3
) (
  input  logic            clk,
  input  logic            rst,
  poly_halve_seq_if.slave bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_COEFFS - 1);

  logic [2:0]         state;
  logic [ADDR_W-1:0]  rd_addr;
  logic [ADDR_W-1:0]  wr_addr;
  logic               wr_en;
  logic [SHIFT_W-1:0] k_q;
  logic [SHIFT_W-1:0] pass_cnt;
  logic [SHIFT_W-1:0] pass_nxt;
  logic               rd_en;

  assign rd_en    = (state == S_READ);
  assign pass_nxt = pass_cnt + SHIFT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      rd_addr  <= '0;
      wr_addr  <= '0;
      wr_en    <= 1'b0;
      k_q      <= '0;
      pass_cnt <= '0;
    end else begin
      // Write port is the read port one cycle late, matching the RAM read latency.
      wr_en   <= rd_en;
      wr_addr <= rd_addr;
      case (state)
        S_IDLE: begin
          if (bus.start_i) begin
            if (bus.shift_i == '0) begin
              state <= S_DONE;
            end else begin
              state    <= S_READ;
              k_q      <= bus.shift_i;
              pass_cnt <= '0;
              rd_addr  <= '0;
            end
          end
        end
        S_READ: begin
          if (rd_addr == LAST_ADDR) begin
            state <= S_DRAIN;
          end else begin
            rd_addr <= rd_addr + ADDR_W'(1);
          end
        end
        S_DRAIN: begin
          // Last write of the pass lands this cycle.
          pass_cnt <= pass_nxt;
          state    <= (pass_nxt == k_q) ? S_DONE : S_GAP;
        end
        S_GAP: begin
          // Idle cycle keeps the next pass's read of address 0 clear of the previous pass's final write.
          rd_addr <= '0;
          state   <= S_READ;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Halving mod 3329: even a -> a/2; odd a -> (a+3329)/2, which equals (a>>1) + 1665.
  // The split form stays within 12 bits and gives the identical result for canonical input.
  logic [11:0] halved;
  assign halved = (bus.rd_data_i >> 1) + (bus.rd_data_i[0] ? 12'd1665 : 12'd0);

  assign bus.rd_en_o   = rd_en;
  assign bus.rd_addr_o = rd_addr;
  assign bus.wr_en_o   = wr_en;
  assign bus.wr_addr_o = wr_addr;
  assign bus.wr_data_o = halved;
  assign bus.busy_o    = (state == S_READ) || (state == S_DRAIN) || (state == S_GAP);
  assign bus.done_o    = (state == S_DONE);

endmodule
